// File: rtl/uart_tx_fifo_if.sv
// Byte-queue bus between the processor port / TX engine side and the uart_tx_fifo.
// The master side drives writes, flush and TXRDY; the slave side returns load, data and status.
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic          wr;
  logic [7:0]    din;
  logic          clr;
  logic          TXRDY;
  logic          load;
  logic [7:0]    OUT_PORT;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          ovf;

  modport master (
    output wr, din, clr, TXRDY,
    input  load, OUT_PORT, empty, full, count, ovf
  );

  modport slave (
    input  wr, din, clr, TXRDY,
    output load, OUT_PORT, empty, full, count, ovf
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte buffer feeding a UART TX engine: one load pulse per byte, issued only
// when TXRDY is high, then held off until TX drops TXRDY or a busy timeout expires.
module uart_tx_fifo #(
  parameter int AW      = 4,
  parameter int BUSY_TO = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** AW;
  localparam int TW    = $clog2(BUSY_TO + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_reg, rptr_reg;
  logic [AW:0]   count_reg;
  logic          ovf_reg;
  logic          load_reg;
  logic [7:0]    out_reg;
  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;

  logic empty_w, full_w, enq, drop, deq;

  assign empty_w = (count_reg == '0);
  assign full_w  = (count_reg == (AW+1)'(DEPTH));

  // Fullness is judged on the registered count, so a same-cycle dequeue never frees a slot.
  assign enq  = bus.wr && !full_w && !bus.clr;
  assign drop = bus.wr &&  full_w && !bus.clr;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    deq        = 1'b0;
    if (bus.clr) begin
      state_next = IDLE;
      timer_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.TXRDY && !empty_w) begin
            deq        = 1'b1;
            state_next = LOAD;
          end
        end
        LOAD: begin
          state_next = WAIT_BUSY;
          timer_next = '0;
        end
        WAIT_BUSY: begin
          // Give up after BUSY_TO cycles so a TX engine that never drops TXRDY cannot stall us.
          if (!bus.TXRDY || timer_reg == TW'(BUSY_TO - 1)) begin
            state_next = IDLE;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      load_reg  <= 1'b0;
      out_reg   <= 8'h00;
    end else if (bus.clr) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      load_reg  <= 1'b0;
    end else begin
      load_reg <= deq;
      if (enq) begin
        wptr_reg <= wptr_reg + AW'(1);
      end
      if (deq) begin
        rptr_reg <= rptr_reg + AW'(1);
        out_reg  <= mem[rptr_reg];
      end
      if (drop) begin
        ovf_reg <= 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wptr_reg] <= bus.din;
    end
  end

  assign bus.load     = load_reg;
  assign bus.OUT_PORT = out_reg;
  assign bus.count    = count_reg;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.ovf      = ovf_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_uart_tx_fifo;
  localparam int AW      = 4;
  localparam int BUSY_TO = 8;
  localparam int DEPTH   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.AW(AW)) bus ();

  logic tx_level = 1'b0;
  logic tx_auto  = 1'b0;
  logic tx_eng   = 1'b1;
  int   tx_cnt   = 0;
  assign bus.TXRDY = tx_auto ? tx_eng : tx_level;

  uart_tx_fifo #(.AW(AW), .BUSY_TO(BUSY_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // TX engine stand-in: drops TXRDY right after seeing load, raises it 10 cycles later.
  always @(negedge clk) begin
    if (!tx_auto) begin
      tx_eng = 1'b1;
      tx_cnt = 0;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_eng = 1'b1;
    end else if (bus.load) begin
      tx_eng = 1'b0;
      tx_cnt = 10;
    end
  end

  // Reference model: a byte queue plus "edge number of last load" bookkeeping.
  byte unsigned mq[$];
  logic         m_ovf;
  logic         m_load;
  logic [7:0]   m_out;
  bit           m_block;
  bit           m_can;
  int           m_last;
  int           m_edge;
  int           m_sz;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0; m_load = 1'b0; m_out = 8'h00; m_block = 1'b0; m_edge = 0; m_last = 0;
    end else begin
      m_edge++;
      if (bus.clr) begin
        mq.delete();
        m_ovf = 1'b0; m_load = 1'b0; m_block = 1'b0;
      end else begin
        m_sz  = mq.size();
        m_can = !m_block;
        if (m_block && m_edge >= m_last + 2 && (!bus.TXRDY || m_edge == m_last + 1 + BUSY_TO))
          m_block = 1'b0;
        m_load = 1'b0;
        if (m_can && bus.TXRDY && m_sz > 0) begin
          m_out   = mq.pop_front();
          m_load  = 1'b1;
          m_block = 1'b1;
          m_last  = m_edge;
        end
        if (bus.wr) begin
          if (m_sz == DEPTH) m_ovf = 1'b1;
          else mq.push_back(bus.din);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; bus.wr = 1'b0; bus.clr = 1'b0; tx_auto = 1'b0; tx_level = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.wr = 1'b1; bus.din = 8'(base + i);
      @(negedge clk);
    end
    bus.wr = 1'b0;
  endtask

  task automatic test_reset();
    bus.wr = 1'b0; bus.din = 8'h00; bus.clr = 1'b0; tx_level = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    checks++; if (bus.load !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", bus.load); end
    checks++; if (bus.OUT_PORT !== 8'h00) begin failures++; $display("FAIL reset_out got=%02h exp=00", bus.OUT_PORT); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    apply_reset();
    tx_level = 1'b1; bus.wr = 1'b1; bus.din = 8'hA5;
    @(negedge clk);
    bus.wr = 1'b0;
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL single_empty1 got=%b exp=0", bus.empty); end
    checks++; if (bus.count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.count); end
    checks++; if (bus.load !== 1'b0) begin failures++; $display("FAIL single_early_load got=%b exp=0", bus.load); end
    @(negedge clk);
    checks++; if (bus.load !== 1'b1) begin failures++; $display("FAIL single_load got=%b exp=1", bus.load); end
    checks++; if (bus.OUT_PORT !== 8'hA5) begin failures++; $display("FAIL single_out got=%02h exp=a5", bus.OUT_PORT); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL single_empty2 got=%b exp=1", bus.empty); end
    @(negedge clk);
    checks++; if (bus.load !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b exp=0", bus.load); end
    $display("test_single done: byte a5 loaded");
  endtask

  task automatic test_fill_overflow();
    int idx;
    int cyc;
    int extra;
    apply_reset();
    fill(16, 0);
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", bus.full); end
    checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", bus.count); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL fill_ovf_early got=%b exp=0", bus.ovf); end
    fill(1, 16);
    checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", bus.ovf); end
    checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL fill_count_ovf got=%0d exp=16", bus.count); end
    tx_auto = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.load === 1'b1) begin
        checks++;
        if (bus.OUT_PORT !== idx[7:0]) begin
          failures++; $display("FAIL drain_order got=%02h exp=%02h", bus.OUT_PORT, idx[7:0]);
        end
        idx++;
      end
    end
    checks++; if (idx != 16) begin failures++; $display("FAIL drain_timeout got=%0d bytes exp=16", idx); end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.load === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL drain_extra_loads got=%0d exp=0", extra); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    tx_auto = 1'b0;
    $display("test_fill_overflow done: %0d bytes drained", idx);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    fill(3, 8'h11);
    checks++; if (bus.count !== 5'd3) begin failures++; $display("FAIL simul_pre_count got=%0d exp=3", bus.count); end
    tx_level = 1'b1; bus.wr = 1'b1; bus.din = 8'h44;
    @(negedge clk);
    bus.wr = 1'b0; tx_level = 1'b0;
    checks++; if (bus.count !== 5'd3) begin failures++; $display("FAIL simul_count got=%0d exp=3", bus.count); end
    checks++; if (bus.load !== 1'b1) begin failures++; $display("FAIL simul_load got=%b exp=1", bus.load); end
    checks++; if (bus.OUT_PORT !== 8'h11) begin failures++; $display("FAIL simul_out got=%02h exp=11", bus.OUT_PORT); end
    apply_reset();
    fill(16, 8'h40);
    tx_level = 1'b1; bus.wr = 1'b1; bus.din = 8'hEE;
    @(negedge clk);
    bus.wr = 1'b0; tx_level = 1'b0;
    checks++; if (bus.count !== 5'd15) begin failures++; $display("FAIL simul_full_count got=%0d exp=15", bus.count); end
    checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL simul_full_ovf got=%b exp=1", bus.ovf); end
    checks++; if (bus.OUT_PORT !== 8'h40) begin failures++; $display("FAIL simul_full_out got=%02h exp=40", bus.OUT_PORT); end
    $display("test_simultaneous done");
  endtask

  task automatic test_busy_timeout();
    int gap;
    bit found;
    apply_reset();
    tx_level = 1'b1;
    bus.wr = 1'b1; bus.din = 8'h5A;
    @(negedge clk);
    bus.din = 8'hC3;
    @(negedge clk);
    bus.wr = 1'b0;
    checks++; if (bus.load !== 1'b1 || bus.OUT_PORT !== 8'h5A) begin failures++; $display("FAIL timeout_first got=%b/%02h exp=1/5a", bus.load, bus.OUT_PORT); end
    gap = 0; found = 1'b0;
    while (!found && gap < 30) begin
      @(negedge clk);
      gap++;
      if (bus.load === 1'b1) found = 1'b1;
    end
    checks++; if (!found || gap != BUSY_TO + 2) begin failures++; $display("FAIL timeout_gap got=%0d exp=%0d", gap, BUSY_TO + 2); end
    checks++; if (bus.OUT_PORT !== 8'hC3) begin failures++; $display("FAIL timeout_second got=%02h exp=c3", bus.OUT_PORT); end
    tx_level = 1'b0;
    $display("test_busy_timeout done: gap=%0d", gap);
  endtask

  task automatic test_clr();
    int cyc;
    int extra;
    apply_reset();
    fill(17, 8'h80);
    checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL clr_pre_ovf got=%b exp=1", bus.ovf); end
    tx_auto = 1'b1;
    cyc = 0;
    while (bus.count !== 5'd5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    tx_auto = 1'b0;
    checks++; if (bus.count !== 5'd5) begin failures++; $display("FAIL clr_pre_count got=%0d exp=5", bus.count); end
    repeat (3) @(negedge clk);
    bus.clr = 1'b1; bus.wr = 1'b1; bus.din = 8'h77;
    @(negedge clk);
    bus.clr = 1'b0; bus.wr = 1'b0;
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL clr_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b exp=0", bus.ovf); end
    tx_level = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.load === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL clr_load got=%0d loads exp=0", extra); end
    tx_level = 1'b0;
    $display("test_clr done");
  endtask

  task automatic test_async_reset();
    apply_reset();
    tx_level = 1'b1;
    bus.wr = 1'b1; bus.din = 8'h31;
    @(negedge clk);
    bus.din = 8'h32;
    @(negedge clk);
    bus.wr = 1'b0;
    checks++; if (bus.load !== 1'b1 || bus.count !== 5'd1) begin failures++; $display("FAIL arst_pre got=%b/%0d exp=1/1", bus.load, bus.count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.load !== 1'b0) begin failures++; $display("FAIL arst_load got=%b exp=0", bus.load); end
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", bus.count); end
    checks++; if (bus.OUT_PORT !== 8'h00) begin failures++; $display("FAIL arst_out got=%02h exp=00", bus.OUT_PORT); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL arst_empty got=%b exp=1", bus.empty); end
    @(negedge clk);
    rst = 1'b1; tx_level = 1'b0;
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int sz;
    int loads;
    apply_reset();
    loads = 0;
    for (int n = 0; n < 800; n++) begin
      bus.wr   = ($urandom_range(0, 9) < 6);
      bus.din  = 8'($urandom);
      bus.clr  = ($urandom_range(0, 49) == 0);
      tx_level = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      sz = mq.size();
      if (m_load) loads++;
      checks++; if (bus.count !== sz[AW:0]) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", n, bus.count, sz); end
      checks++; if (bus.empty !== (sz == 0)) begin failures++; $display("FAIL rand_empty cyc=%0d got=%b", n, bus.empty); end
      checks++; if (bus.full !== (sz == DEPTH)) begin failures++; $display("FAIL rand_full cyc=%0d got=%b", n, bus.full); end
      checks++; if (bus.ovf !== m_ovf) begin failures++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", n, bus.ovf, m_ovf); end
      checks++; if (bus.load !== m_load) begin failures++; $display("FAIL rand_load cyc=%0d got=%b exp=%b", n, bus.load, m_load); end
      checks++; if (bus.OUT_PORT !== m_out) begin failures++; $display("FAIL rand_out cyc=%0d got=%02h exp=%02h", n, bus.OUT_PORT, m_out); end
    end
    bus.wr = 1'b0; bus.clr = 1'b0; tx_level = 1'b0;
    $display("test_random done: %0d loads predicted", loads);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr = 1'b0; bus.din = 8'h00; bus.clr = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_simultaneous();
    test_busy_timeout();
    test_clr();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
